// File: rtl/ez90_pkg.sv
// Shared eZ90 definitions used by the retirement controller.
package ez90_pkg;

    // Trap sequencer states; values are visible on the debug state port.
    typedef enum logic [1:0] {
        TS_IDLE     = 2'd0,
        TS_FLUSH    = 2'd1,
        TS_REDIRECT = 2'd2,
        TS_HALT     = 2'd3
    } ez90_trapseq_state_e;

    // Each vector slot is one 32-bit word, so the cause index is scaled by 4.
    localparam int EZ90_TRAP_VEC_SHIFT = 2;

    // Vectored redirect target: base plus the low six cause bits as a word
    // index. The add wraps modulo 2^32.
    function automatic logic [31:0] ez90_trap_vector(input logic [31:0] base,
                                                     input logic [5:0]  cause_idx);
        logic [31:0] offset;
        offset = {26'd0, cause_idx} << EZ90_TRAP_VEC_SHIFT;
        return base + offset;
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Retirement controller for the eZ90 P7 core. Gates retirement into the
// commit stage, and sequences trap recovery: freeze, flush handshake with a
// timeout, then a vectored front-end redirect. Also provides a debug halt
// that stops retirement between instructions.
//
// Handshakes: flush_req stays high until flush_ack is seen, or until the
// drain counter expires. redirect_valid and redirect_pc stay stable until a
// cycle with redirect_ready high; the transfer completes on that edge.
module trap_sequencer
    import ez90_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          DRAIN_MAX = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                commit_valid,
    input  logic                commit_has_trap,
    input  logic [31:0]         commit_trap_cause,
    input  logic [31:0]         commit_trap_epc,
    input  logic                halt_req,
    input  logic                flush_ack,
    input  logic                redirect_ready,
    output logic                retire_en,
    output logic                flush_req,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic [31:0]         epc_q,
    output logic [31:0]         cause_q,
    output logic [31:0]         trap_count,
    output logic                halted,
    output logic                drain_timeout,
    output ez90_trapseq_state_e dbg_state
);

    // The last drain-counter value before the flush is abandoned.
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    ez90_trapseq_state_e state_q;
    logic                retire_en_q;
    logic                flush_req_q;
    logic                redirect_valid_q;
    logic                halted_q;
    logic                drain_timeout_q;
    logic [31:0]         redirect_pc_q;
    logic [31:0]         trap_count_q;
    logic [7:0]          drain_q;

    logic [31:0]         trap_count_d;
    logic [7:0]          drain_d;
    logic [31:0]         redirect_pc_d;
    logic                trap_take;
    logic                drain_done;

    // Next values for the counters and the redirect target.
    always_comb begin
        trap_count_d  = (trap_count_q == 32'hFFFF_FFFF) ? trap_count_q : trap_count_q + 32'd1;
        drain_d       = drain_q + 8'd1;
        redirect_pc_d = ez90_trap_vector(VEC_BASE, cause_q[5:0]);
        trap_take     = commit_valid && commit_has_trap;
        drain_done    = (drain_q == DRAIN_LAST);
    end

    // Sequencer FSM; all outputs are registered alongside the state, so
    // retire_en has no combinational path from the commit stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= TS_IDLE;
            retire_en_q      <= 1'b1;
            flush_req_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            halted_q         <= 1'b0;
            drain_timeout_q  <= 1'b0;
            redirect_pc_q    <= 32'd0;
            epc_q            <= 32'd0;
            cause_q          <= 32'd0;
            trap_count_q     <= 32'd0;
            drain_q          <= 8'd0;
        end else begin
            case (state_q)
                TS_IDLE: begin
                    // A trap wins over a simultaneous halt request.
                    if (trap_take) begin
                        epc_q        <= commit_trap_epc;
                        cause_q      <= commit_trap_cause;
                        trap_count_q <= trap_count_d;
                        drain_q      <= 8'd0;
                        state_q      <= TS_FLUSH;
                        retire_en_q  <= 1'b0;
                        flush_req_q  <= 1'b1;
                    end else if (halt_req) begin
                        state_q     <= TS_HALT;
                        retire_en_q <= 1'b0;
                        halted_q    <= 1'b1;
                    end
                end
                TS_FLUSH: begin
                    drain_q <= drain_d;
                    // An ack on the expiry cycle still counts as a clean flush.
                    if (flush_ack || drain_done) begin
                        if (!flush_ack) begin
                            drain_timeout_q <= 1'b1;
                        end
                        state_q          <= TS_REDIRECT;
                        flush_req_q      <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= redirect_pc_d;
                    end
                end
                TS_REDIRECT: begin
                    if (redirect_ready) begin
                        state_q          <= TS_IDLE;
                        redirect_valid_q <= 1'b0;
                        retire_en_q      <= 1'b1;
                    end
                end
                TS_HALT: begin
                    if (!halt_req) begin
                        state_q     <= TS_IDLE;
                        halted_q    <= 1'b0;
                        retire_en_q <= 1'b1;
                    end
                end
                default: begin
                    state_q          <= TS_IDLE;
                    retire_en_q      <= 1'b1;
                    flush_req_q      <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    halted_q         <= 1'b0;
                end
            endcase
        end
    end

    assign retire_en      = retire_en_q;
    assign flush_req      = flush_req_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign trap_count     = trap_count_q;
    assign halted         = halted_q;
    assign drain_timeout  = drain_timeout_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer. Each trap pushes its expected redirect
// {pc, epc, cause, count} into exp_q; a monitor pops and compares whenever a
// redirect is accepted. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.
module tb_trap_sequencer;
  import ez90_pkg::*;

  logic clk;
  logic rst_n;
  logic commit_valid;
  logic commit_has_trap;
  logic [31:0] commit_trap_cause;
  logic [31:0] commit_trap_epc;
  logic halt_req;
  logic flush_ack;
  logic redirect_ready;
  logic retire_en;
  logic flush_req;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [31:0] trap_count;
  logic halted;
  logic drain_timeout;
  ez90_trapseq_state_e dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int n_flush;
  logic [127:0] exp_q[$];

  trap_sequencer #(.VEC_BASE(32'h0000_0100), .DRAIN_MAX(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .commit_valid(commit_valid),
    .commit_has_trap(commit_has_trap),
    .commit_trap_cause(commit_trap_cause),
    .commit_trap_epc(commit_trap_epc),
    .halt_req(halt_req),
    .flush_ack(flush_ack),
    .redirect_ready(redirect_ready),
    .retire_en(retire_en),
    .flush_req(flush_req),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .epc_q(epc_q),
    .cause_q(cause_q),
    .trap_count(trap_count),
    .halted(halted),
    .drain_timeout(drain_timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // driver tasks
  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_commit(input logic [31:0] cause, input logic [31:0] epc);
    commit_valid = 1'b1;
    commit_has_trap = 1'b1;
    commit_trap_cause = cause;
    commit_trap_epc = epc;
  endtask

  task automatic clr_commit();
    commit_valid = 1'b0;
    commit_has_trap = 1'b0;
    commit_trap_cause = 32'd0;
    commit_trap_epc = 32'd0;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] epc,
                          input logic [31:0] cause, input logic [31:0] cnt);
    exp_q.push_back({pc, epc, cause, cnt});
  endtask

  // scoreboard monitor: every accepted redirect is checked against exp_q
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst_n && redirect_valid && redirect_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_redirect: got pc 0x%08h expected no redirect", redirect_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_redirect_pc", redirect_pc, e[127:96]);
        chk("sb_epc", epc_q, e[95:64]);
        chk("sb_cause", cause_q, e[63:32]);
        chk("sb_trap_count", trap_count, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr_commit();
    halt_req = 1'b0;
    flush_ack = 1'b0;
    redirect_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset values
    mid();
    chk("rst_retire_en", 32'(retire_en), 32'd1);
    chk("rst_flush_req", 32'(flush_req), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_epc", epc_q, 32'd0);
    chk("rst_cause", cause_q, 32'd0);
    chk("rst_trap_count", trap_count, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_drain_timeout", 32'(drain_timeout), 32'd0);
    cyc_end();

    // reset asserted in FLUSH aborts the sequence
    set_commit(32'h9, 32'h800);
    mid();
    cyc_end();
    clr_commit();
    mid();
    chk("abort_pre_flush_req", 32'(flush_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_flush_req", 32'(flush_req), 32'd0);
    chk("abort_retire_en", 32'(retire_en), 32'd1);
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_trap_count", trap_count, 32'd0);
    cyc_end();
    rst_n = 1'b1;
    mid();
    chk("abort_no_redirect", 32'(redirect_valid), 32'd0);
    cyc_end();

    // basic trap: cause 5, epc 0x1234, ack at T+3, ready at T+5
    set_commit(32'h5, 32'h1234);
    push_exp(32'h114, 32'h1234, 32'h5, 32'd1);
    mid();
    chk("basic_T_retire_en", 32'(retire_en), 32'd1);
    cyc_end();
    clr_commit();
    mid();
    chk("basic_T1_flush_req", 32'(flush_req), 32'd1);
    chk("basic_T1_retire_en", 32'(retire_en), 32'd0);
    cyc_end();
    mid();
    chk("basic_T2_flush_req", 32'(flush_req), 32'd1);
    cyc_end();
    flush_ack = 1'b1;
    mid();
    chk("basic_T3_flush_req", 32'(flush_req), 32'd1);
    cyc_end();
    flush_ack = 1'b0;
    mid();
    chk("basic_T4_flush_req", 32'(flush_req), 32'd0);
    chk("basic_T4_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("basic_T4_redirect_pc", redirect_pc, 32'h114);
    chk("basic_T4_retire_en", 32'(retire_en), 32'd0);
    cyc_end();
    redirect_ready = 1'b1;
    mid();
    chk("basic_T5_redirect_pc", redirect_pc, 32'h114);
    cyc_end();
    redirect_ready = 1'b0;
    mid();
    chk("basic_T6_retire_en", 32'(retire_en), 32'd1);
    chk("basic_T6_trap_count", trap_count, 32'd1);
    chk("basic_T6_timeout", 32'(drain_timeout), 32'd0);
    cyc_end();

    // flush timeout: no ack, flush_req must last exactly 16 cycles
    set_commit(32'h10, 32'h2000);
    push_exp(32'h140, 32'h2000, 32'h10, 32'd2);
    mid();
    cyc_end();
    clr_commit();
    n_flush = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (!flush_req) break;
      if (n_flush == 14) chk("tmo_not_yet", 32'(drain_timeout), 32'd0);
      n_flush++;
      cyc_end();
    end
    chk("tmo_flush_cycles", 32'(n_flush), 32'd16);
    chk("tmo_drain_timeout", 32'(drain_timeout), 32'd1);
    chk("tmo_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("tmo_redirect_pc", redirect_pc, 32'h140);
    cyc_end();
    redirect_ready = 1'b1;
    mid();
    cyc_end();
    redirect_ready = 1'b0;
    mid();
    chk("tmo_retire_en", 32'(retire_en), 32'd1);
    cyc_end();

    // clean trap afterwards: sticky timeout flag survives
    set_commit(32'h1, 32'h3000);
    push_exp(32'h104, 32'h3000, 32'h1, 32'd3);
    mid();
    cyc_end();
    clr_commit();
    flush_ack = 1'b1;
    mid();
    cyc_end();
    flush_ack = 1'b0;
    redirect_ready = 1'b1;
    mid();
    chk("clean_redirect_valid", 32'(redirect_valid), 32'd1);
    cyc_end();
    redirect_ready = 1'b0;
    mid();
    chk("clean_sticky_timeout", 32'(drain_timeout), 32'd1);
    chk("clean_retire_en", 32'(retire_en), 32'd1);
    chk("clean_trap_count", trap_count, 32'd3);
    cyc_end();

    // trap and halt in the same cycle: trap first, then HALT
    set_commit(32'h2, 32'h4000);
    halt_req = 1'b1;
    push_exp(32'h108, 32'h4000, 32'h2, 32'd4);
    mid();
    cyc_end();
    clr_commit();
    flush_ack = 1'b1;
    mid();
    chk("th_T1_flush_req", 32'(flush_req), 32'd1);
    chk("th_T1_halted", 32'(halted), 32'd0);
    cyc_end();
    flush_ack = 1'b0;
    redirect_ready = 1'b1;
    mid();
    chk("th_T2_redirect_valid", 32'(redirect_valid), 32'd1);
    cyc_end();
    redirect_ready = 1'b0;
    mid();
    chk("th_T3_retire_en", 32'(retire_en), 32'd1);
    chk("th_T3_halted", 32'(halted), 32'd0);
    cyc_end();
    set_commit(32'h9, 32'hBAD0);
    mid();
    chk("th_T4_halted", 32'(halted), 32'd1);
    chk("th_T4_retire_en", 32'(retire_en), 32'd0);
    cyc_end();
    clr_commit();
    halt_req = 1'b0;
    mid();
    chk("th_T5_halted", 32'(halted), 32'd1);
    chk("th_T5_flush_req", 32'(flush_req), 32'd0);
    cyc_end();
    mid();
    chk("th_T6_retire_en", 32'(retire_en), 32'd1);
    chk("th_T6_halted", 32'(halted), 32'd0);
    chk("th_T6_trap_count", trap_count, 32'd4);
    chk("th_T6_epc", epc_q, 32'h4000);
    cyc_end();

    // redirect backpressure with commit pulses injected
    set_commit(32'h7, 32'h5000);
    push_exp(32'h11C, 32'h5000, 32'h7, 32'd5);
    mid();
    cyc_end();
    clr_commit();
    flush_ack = 1'b1;
    mid();
    cyc_end();
    flush_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 4) set_commit(32'h33, 32'hDEAD);
      else clr_commit();
      mid();
      chk("bp_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("bp_redirect_pc", redirect_pc, 32'h11C);
      cyc_end();
    end
    clr_commit();
    chk("bp_epc_held", epc_q, 32'h5000);
    chk("bp_count_held", trap_count, 32'd5);
    redirect_ready = 1'b1;
    mid();
    cyc_end();
    redirect_ready = 1'b0;
    mid();
    chk("bp_retire_en", 32'(retire_en), 32'd1);
    chk("bp_trap_count", trap_count, 32'd5);
    cyc_end();

    // saturating trap counter and wrap of the cause index
    force dut.trap_count_q = 32'hFFFF_FFFF;
    cyc_end();
    release dut.trap_count_q;
    mid();
    chk("sat_preload", trap_count, 32'hFFFF_FFFF);
    cyc_end();
    set_commit(32'hFFFF_FFFF, 32'h6000);
    push_exp(32'h1FC, 32'h6000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mid();
    cyc_end();
    clr_commit();
    flush_ack = 1'b1;
    mid();
    cyc_end();
    flush_ack = 1'b0;
    redirect_ready = 1'b1;
    mid();
    chk("sat_redirect_pc", redirect_pc, 32'h1FC);
    cyc_end();
    redirect_ready = 1'b0;
    mid();
    chk("sat_trap_count", trap_count, 32'hFFFF_FFFF);
    chk("sat_retire_en", 32'(retire_en), 32'd1);
    cyc_end();

    // final report
    repeat (2) cyc_end();
    chk("sb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
